hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Pipeline hazard unit for the 5-stage MIPS core. It sits directly downstream of the decode-stage controller and consumes that controller's per-instruction `Tuse`/`Tnew`/register-use outputs. It keeps a registered scoreboard of the in-flight writers in E, M and W, and produces:
- the stall/bubble request,
- the D, E and M forwarding selects,
- a saturating stall-cycle counter.

## Interface
Parameters:
- `CNT_W`, 32, width of stall counter.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Synchronous, active-high; clears all state.
- `D_A1`  in  5  D-stage rs number.
- `D_A2`  in  5  D-stage rt number.
- `D_A1use`  in  1  D instruction reads rs.
- `D_A2use`  in  1  D instruction reads rt.
- `D_rs_Tuse`  in  4  Cycles from D until rs is needed (5 = never).
- `D_rt_Tuse`  in  4  Cycles from D until rt is needed (5 = never).
- `D_Tnew`  in  4  Cycles from D until the result exists (0 = no result).
- `D_Reg_Write`  in  1  D instruction writes the GPR file.
- `D_Wr_Addr`  in  5  Final destination after the RegDst/jal mux (rd, rt or 31).
- `stall`  out  1  Freeze PC and F/D register; load a bubble into D/E.
- `fwd_D_rs`, `fwd_D_rt`  out  2  0 = RF, 1 = E-stage result, 2 = M-stage result.
- `fwd_E_rs`, `fwd_E_rt`  out  2  0 = D/E pipe value, 1 = M result, 2 = W result.
- `fwd_M_rt`  out  1  0 = E/M pipe value, 1 = W result.
- `stall_cnt`  out  `CNT_W`  Number of stalled cycles, saturating.

## Operation
- Three registered entries: E, M, W.
  - Each entry holds `{wr, a3[4:0], tnew[3:0]}`.
  - E additionally holds `a1`, `a2`.
  - M additionally holds `a2`.
- An entry is a live writer iff `wr=1` and `a3!=0`. A write to `$0` never matches anything.
- `sat(x)` is `x-1` if `x>0`, otherwise `0`.
- Stall, combinational:
  - `stall_rs = D_A1use & D_A1!=0 & ((E live & E.a3==D_A1 & E.tnew>D_rs_Tuse) | (M live & M.a3==D_A1 & M.tnew>D_rs_Tuse))`.
  - `stall_rt` is the same expression using `A2`/`rt_Tuse`.
  - `stall = stall_rs | stall_rt`.
  - W never causes a stall: its `tnew` is always 0.
- Forward selects, combinational. A source is eligible iff it is live, its `a3` matches, and its `tnew==0`.
  - `fwd_D_*`: E has priority over M. Otherwise 0. The register file bypasses W→D internally.
  - `fwd_E_*`: uses `E.a1`/`E.a2`; M has priority over W.
  - `fwd_M_rt`: uses `M.a2` against W.
  - All selects are 0 when the matched register is `$0`.
- Shift on every clock edge when `reset=0`:
  - W ← `{M.wr, M.a3, sat(M.tnew)}`.
  - M ← `{E.wr, E.a3, sat(E.tnew), E.a2}`.
  - If `stall=1`: E ← bubble (`wr=0`, `a3=0`, `tnew=0`, `a1=0`, `a2=0`).
  - Otherwise: E ← `{D_Reg_Write, D_Wr_Addr, sat(D_Tnew), D_A1, D_A2}`.
- `stall_cnt` increments by 1 on each edge with `stall=1`. It holds at `2^CNT_W-1` and does not wrap.

## Timing
- Reset values: all entries zero; `stall=0`; all `fwd_*=0`; `stall_cnt=0`.
  - Every output is 0 in the cycle after reset, because no entry is live.
- A reset asserted mid-stall overrides everything: entries clear on that edge and `stall_cnt` clears.
- `stall` and `fwd_*` are combinational from the D inputs and the registered entries, valid in the same cycle.
- No output is registered except `stall_cnt`, which has one-cycle latency.
- A stall lasts until the blocking entry's `tnew` falls to `Tuse` or below:
  - at most 2 cycles (lw followed by beq);
  - the bubble in E makes the following stall check consider only the advancing writer.
- When E and M both match the same register, E wins for D-stage forwarding (newest value). Likewise M over W for E-stage forwarding.
- `D_Tnew=0` produces `tnew=0` with `wr` as given. Instructions with `D_Reg_Write=0` are never live.

## Test plan
- Reset held 2 cycles, then released with all D inputs 0 → `stall=0`, all `fwd_*=0`, `stall_cnt=0`.
- `lw $8` (Tnew 3, wr, A3 8), then `add $9,$8,$1` (A1 8, rs_Tuse 1):
  - add's first D cycle → `stall=1`; add's second D cycle → `stall=0`, `stall_cnt=1`;
  - next cycle, add in E → `fwd_E_rs=2`.
- `add $5` (Tnew 2), then `beq $5,$6` (rs/rt Tuse 0):
  - beq's first D cycle → `stall=1`; beq's second D cycle → `stall=0`, `fwd_D_rs=2`, `fwd_D_rt=0`.
- `jal` (Tnew 1, A3 31), then `jr $31` (rs_Tuse 0) → `stall=0`, `fwd_D_rs=1`.
- `ori $0` (Tnew 2, wr, A3 0), then `add $2,$0,$0` → `stall=0`, all `fwd_*=0`.
- `lw $4` (Tnew 3), then `sw $4` (rt_Tuse 2, A2 4) → no stall; when sw reaches M → `fwd_M_rt=1`.
- Force a stall for 2^CNT_W+3 cycles (`CNT_W=4` build) → `stall_cnt` saturates at 15 and holds.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage MIPS core: tracks E/M/W writers and produces the
// stall request, the D/E/M forwarding selects and a saturating stall counter.
module hazard_scoreboard #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       D_A1,
   input  logic [4:0]       D_A2,
   input  logic             D_A1use,
   input  logic             D_A2use,
   input  logic [3:0]       D_rs_Tuse,
   input  logic [3:0]       D_rt_Tuse,
   input  logic [3:0]       D_Tnew,
   input  logic             D_Reg_Write,
   input  logic [4:0]       D_Wr_Addr,
   output logic             stall,
   output logic [1:0]       fwd_D_rs,
   output logic [1:0]       fwd_D_rt,
   output logic [1:0]       fwd_E_rs,
   output logic [1:0]       fwd_E_rt,
   output logic             fwd_M_rt,
   output logic [CNT_W-1:0] stall_cnt
);

   logic       e_wr_q, m_wr_q, w_wr_q;
   logic [4:0] e_a3_q, m_a3_q, w_a3_q;
   logic [3:0] e_tnew_q, m_tnew_q, w_tnew_q;
   logic [4:0] e_a1_q, e_a2_q, m_a2_q;

   logic e_live, m_live, w_live;
   logic stall_rs, stall_rt;

   function automatic logic [3:0] sat(input logic [3:0] x);
      return (x != 4'd0) ? x - 4'd1 : 4'd0;
   endfunction

   assign e_live = e_wr_q & (e_a3_q != 5'd0);
   assign m_live = m_wr_q & (m_a3_q != 5'd0);
   assign w_live = w_wr_q & (w_a3_q != 5'd0);

   // W never stalls: its remaining latency is always zero.
   always_comb begin
      stall_rs = D_A1use & (D_A1 != 5'd0) &
                 ((e_live & (e_a3_q == D_A1) & (e_tnew_q > D_rs_Tuse)) |
                  (m_live & (m_a3_q == D_A1) & (m_tnew_q > D_rs_Tuse)));
      stall_rt = D_A2use & (D_A2 != 5'd0) &
                 ((e_live & (e_a3_q == D_A2) & (e_tnew_q > D_rt_Tuse)) |
                  (m_live & (m_a3_q == D_A2) & (m_tnew_q > D_rt_Tuse)));
      stall    = stall_rs | stall_rt;
   end

   // A source forwards only once its result exists (tnew == 0).
   always_comb begin
      fwd_D_rs = 2'd0;
      fwd_D_rt = 2'd0;
      fwd_E_rs = 2'd0;
      fwd_E_rt = 2'd0;
      fwd_M_rt = 1'b0;

      if (e_live && e_a3_q == D_A1 && e_tnew_q == 4'd0)      fwd_D_rs = 2'd1;
      else if (m_live && m_a3_q == D_A1 && m_tnew_q == 4'd0) fwd_D_rs = 2'd2;

      if (e_live && e_a3_q == D_A2 && e_tnew_q == 4'd0)      fwd_D_rt = 2'd1;
      else if (m_live && m_a3_q == D_A2 && m_tnew_q == 4'd0) fwd_D_rt = 2'd2;

      if (m_live && m_a3_q == e_a1_q && m_tnew_q == 4'd0)      fwd_E_rs = 2'd1;
      else if (w_live && w_a3_q == e_a1_q && w_tnew_q == 4'd0) fwd_E_rs = 2'd2;

      if (m_live && m_a3_q == e_a2_q && m_tnew_q == 4'd0)      fwd_E_rt = 2'd1;
      else if (w_live && w_a3_q == e_a2_q && w_tnew_q == 4'd0) fwd_E_rt = 2'd2;

      if (w_live && w_a3_q == m_a2_q && w_tnew_q == 4'd0) fwd_M_rt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_wr_q   <= 1'b0;
         e_a3_q   <= 5'd0;
         e_tnew_q <= 4'd0;
         e_a1_q   <= 5'd0;
         e_a2_q   <= 5'd0;
         m_wr_q   <= 1'b0;
         m_a3_q   <= 5'd0;
         m_tnew_q <= 4'd0;
         m_a2_q   <= 5'd0;
         w_wr_q   <= 1'b0;
         w_a3_q   <= 5'd0;
         w_tnew_q <= 4'd0;
      end else begin
         w_wr_q   <= m_wr_q;
         w_a3_q   <= m_a3_q;
         w_tnew_q <= sat(m_tnew_q);
         m_wr_q   <= e_wr_q;
         m_a3_q   <= e_a3_q;
         m_tnew_q <= sat(e_tnew_q);
         m_a2_q   <= e_a2_q;
         if (stall) begin
            e_wr_q   <= 1'b0;
            e_a3_q   <= 5'd0;
            e_tnew_q <= 4'd0;
            e_a1_q   <= 5'd0;
            e_a2_q   <= 5'd0;
         end else begin
            e_wr_q   <= D_Reg_Write;
            e_a3_q   <= D_Wr_Addr;
            e_tnew_q <= sat(D_Tnew);
            e_a1_q   <= D_A1;
            e_a2_q   <= D_A2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall && stall_cnt != {CNT_W{1'b1}}) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a pipeline-history model predicts the
// outputs of every D cycle; a separate monitor compares them against the DUT.
module tb_hazard_scoreboard;

   localparam int unsigned CW = 4;
   localparam int SAT_MAX = (1 << CW) - 1;

   logic          clk, reset;
   logic [4:0]    D_A1, D_A2, D_Wr_Addr;
   logic          D_A1use, D_A2use, D_Reg_Write;
   logic [3:0]    D_rs_Tuse, D_rt_Tuse, D_Tnew;
   logic          stall, fwd_M_rt;
   logic [1:0]    fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
   logic [CW-1:0] stall_cnt;

   hazard_scoreboard #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .D_A1(D_A1), .D_A2(D_A2), .D_A1use(D_A1use), .D_A2use(D_A2use),
      .D_rs_Tuse(D_rs_Tuse), .D_rt_Tuse(D_rt_Tuse), .D_Tnew(D_Tnew),
      .D_Reg_Write(D_Reg_Write), .D_Wr_Addr(D_Wr_Addr),
      .stall(stall), .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
      .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt),
      .stall_cnt(stall_cnt)
   );

   typedef struct {
      int a1, a2, u1, u2, rs_tuse, rt_tuse, tnew, wr, wa;
   } ins_t;

   // One instruction as it entered E; its remaining latency in stage k
   // (E=1, M=2, W=3) is max(tnew - k, 0).
   typedef struct {
      int wr, a3, tnew, a1, a2;
   } rec_t;

   typedef struct {
      int st, fdrs, fdrt, fers, fert, fmrt, cnt;
   } exp_t;

   exp_t sb[$];
   rec_t hist[$];
   int   model_cnt;
   int   n_tests = 0;
   int   n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ins_t mk(int a1, int u1, int rs_tuse, int a2, int u2, int rt_tuse,
                               int tnew, int wr, int wa);
      ins_t i;
      i.a1 = a1; i.u1 = u1; i.rs_tuse = rs_tuse;
      i.a2 = a2; i.u2 = u2; i.rt_tuse = rt_tuse;
      i.tnew = tnew; i.wr = wr; i.wa = wa;
      return i;
   endfunction

   function automatic rec_t bubble();
      rec_t r;
      r.wr = 0; r.a3 = 0; r.tnew = 0; r.a1 = 0; r.a2 = 0;
      return r;
   endfunction

   function automatic int left(int k);
      return (hist[k-1].tnew > k) ? hist[k-1].tnew - k : 0;
   endfunction

   function automatic bit writes(int k, int a);
      return hist[k-1].wr != 0 && hist[k-1].a3 != 0 && hist[k-1].a3 == a;
   endfunction

   function automatic bit ready(int k, int a);
      return a != 0 && writes(k, a) && left(k) == 0;
   endfunction

   function automatic bit must_wait(int use_it, int a, int tuse);
      if (use_it == 0 || a == 0) return 1'b0;
      for (int k = 1; k <= 2; k++)
         if (writes(k, a) && left(k) > tuse) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int pick(int a, int first, int second);
      if (ready(first, a)) return 1;
      if (ready(second, a)) return 2;
      return 0;
   endfunction

   function automatic exp_t predict(ins_t i);
      exp_t e;
      e.st   = (must_wait(i.u1, i.a1, i.rs_tuse) || must_wait(i.u2, i.a2, i.rt_tuse)) ? 1 : 0;
      e.fdrs = pick(i.a1, 1, 2);
      e.fdrt = pick(i.a2, 1, 2);
      e.fers = pick(hist[0].a1, 2, 3);
      e.fert = pick(hist[0].a2, 2, 3);
      e.fmrt = ready(3, hist[1].a2) ? 1 : 0;
      e.cnt  = model_cnt;
      return e;
   endfunction

   task automatic model_clear();
      hist.delete();
      for (int k = 0; k < 3; k++) hist.push_back(bubble());
      model_cnt = 0;
   endtask

   task automatic model_advance(ins_t i, int st);
      rec_t r;
      if (st != 0) r = bubble();
      else begin
         r.wr = i.wr; r.a3 = i.wa; r.tnew = i.tnew; r.a1 = i.a1; r.a2 = i.a2;
      end
      hist.push_front(r);
      void'(hist.pop_back());
      if (st != 0 && model_cnt < SAT_MAX) model_cnt++;
   endtask

   task automatic chk(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic step(ins_t i, output int st);
      exp_t e;
      @(negedge clk);
      reset       = 1'b0;
      D_A1        = 5'(i.a1);
      D_A2        = 5'(i.a2);
      D_A1use     = 1'(i.u1);
      D_A2use     = 1'(i.u2);
      D_rs_Tuse   = 4'(i.rs_tuse);
      D_rt_Tuse   = 4'(i.rt_tuse);
      D_Tnew      = 4'(i.tnew);
      D_Reg_Write = 1'(i.wr);
      D_Wr_Addr   = 5'(i.wa);
      e = predict(i);
      sb.push_back(e);
      model_advance(i, e.st);
      st = e.st;
   endtask

   // A real pipeline holds the D instruction while stalled.
   task automatic issue(ins_t i);
      int st, n;
      n = 0;
      do begin
         step(i, st);
         n++;
      end while (st != 0 && n < 8);
      if (st != 0) chk("stall_bound", n, 3);
   endtask

   task automatic nops(int n);
      for (int k = 0; k < n; k++) issue(mk(0, 0, 5, 0, 0, 5, 0, 0, 0));
   endtask

   task automatic do_reset(int cycles);
      @(negedge clk);
      reset = 1'b1;
      repeat (cycles) @(posedge clk);
      model_clear();
   endtask

   // Monitor: one expectation per D cycle, sampled mid-low-phase.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall",     int'(stall),     e.st);
            chk("fwd_D_rs",  int'(fwd_D_rs),  e.fdrs);
            chk("fwd_D_rt",  int'(fwd_D_rt),  e.fdrt);
            chk("fwd_E_rs",  int'(fwd_E_rs),  e.fers);
            chk("fwd_E_rt",  int'(fwd_E_rt),  e.fert);
            chk("fwd_M_rt",  int'(fwd_M_rt),  e.fmrt);
            chk("stall_cnt", int'(stall_cnt), e.cnt);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      reset = 1'b1;
      D_A1 = '0; D_A2 = '0; D_A1use = 1'b0; D_A2use = 1'b0;
      D_rs_Tuse = 4'd5; D_rt_Tuse = 4'd5; D_Tnew = '0;
      D_Reg_Write = 1'b0; D_Wr_Addr = '0;
      model_clear();

      do_reset(2);
      nops(2);

      // lw $8 ; add $9,$8,$1
      issue(mk(0, 0, 5, 0, 0, 5, 3, 1, 8));
      issue(mk(8, 1, 1, 1, 1, 1, 2, 1, 9));
      nops(3);

      // add $5 ; beq $5,$6
      issue(mk(1, 1, 1, 2, 1, 1, 2, 1, 5));
      issue(mk(5, 1, 0, 6, 1, 0, 0, 0, 0));
      nops(3);

      // jal ; jr $31
      issue(mk(0, 0, 5, 0, 0, 5, 1, 1, 31));
      issue(mk(31, 1, 0, 0, 0, 5, 0, 0, 0));
      nops(3);

      // ori $0 ; add $2,$0,$0
      issue(mk(0, 1, 1, 0, 0, 5, 2, 1, 0));
      issue(mk(0, 1, 1, 0, 1, 1, 2, 1, 2));
      nops(3);

      // lw $4 ; sw $4
      issue(mk(0, 0, 5, 0, 0, 5, 3, 1, 4));
      issue(mk(29, 1, 1, 4, 1, 2, 0, 0, 0));
      nops(4);

      // Reset asserted while a stall is in progress
      issue(mk(0, 0, 5, 0, 0, 5, 3, 1, 8));
      step(mk(8, 1, 1, 0, 0, 5, 2, 1, 9), st);
      do_reset(1);
      nops(3);

      // Repeated lw/beq pairs drive the counter into saturation
      for (int k = 0; k < 10; k++) begin
         issue(mk(0, 0, 5, 0, 0, 5, 3, 1, 8));
         issue(mk(8, 1, 0, 0, 1, 0, 0, 0, 0));
      end
      nops(3);

      do_reset(1);
      nops(1);
      for (int k = 0; k < 300; k++)
         issue(mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 5),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 5),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3)));
      nops(3);

      repeat (2) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
